rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
- Shares the single GPR register-file write port between two requesters.
- Primary requester: the write-back stage, in order, one result per cycle.
- Secondary requester: long-latency units (multi-cycle divider, late load return), which hand results over with a valid/ready handshake.
- Secondary results wait in a small in-order buffer. The block forces a write-back stall when that buffer is starved, and gives the hazard unit a forwarding view of buffered data.

Parameters:
- DEPTH, 2, entries in the secondary buffer (power of two, >=2)
- STARVE_LIMIT, 4, consecutive cycles a buffered head may be denied the port before stall_req asserts
- ADDR_W, 5, register address width
- DATA_W, 32, register data width

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- wb_we  input  1  write-back requests a register write
- wb_addr  input  ADDR_W  write-back destination register
- wb_data  input  DATA_W  write-back data
- aux_valid  input  1  secondary result offered
- aux_ready  output  1  buffer can accept a secondary result
- aux_addr  input  ADDR_W  secondary destination register
- aux_data  input  DATA_W  secondary data
- rf_we  output  1  register-file write enable
- rf_addr  output  ADDR_W  register-file write address
- rf_data  output  DATA_W  register-file write data
- stall_req  output  1  hold the write-back stage this cycle
- q_addr  input  ADDR_W  forwarding query address
- q_hit  output  1  q_addr matches a live buffered entry
- q_data  output  DATA_W  data of the youngest matching live entry

Behaviour:
- Reset (reset=0, asynchronous):
  - buffer emptied; starvation counter cleared
  - aux_ready=1; rf_we=0; rf_addr=0; rf_data=0; stall_req=0; q_hit=0; q_data=0
- Port outputs rf_* are combinational in the current cycle (zero latency).
- Handshake and push:
  - aux_ready = !full.
  - Push occurs when aux_valid && aux_ready.
  - aux_addr==0: the push is accepted and discarded (not stored).
  - A full buffer is never bypassed.
- Entry contents: {live, addr, data}.
- Port selection, per cycle:
  - Primary: stall_req==0 && wb_we && wb_addr!=0. rf_* = wb_*. If the head is not live, it pops in the same cycle without using the port.
  - Drain: otherwise, if the buffer is non-empty, the head pops. rf_we = head.live; rf_addr/rf_data come from the head.
  - Otherwise rf_we=0, and rf_addr/rf_data are driven 0.
- Kill (WAW ordering): a primary write to address A clears live on every buffered entry with addr==A in the same edge. A push to A in that same cycle stays live.
- Starvation counter (0..STARVE_LIMIT, saturating):
  - cleared on pop or when the buffer is empty
  - increments on cycles when the buffer is non-empty and no pop occurs
- stall_req = (count==STARVE_LIMIT) && !empty.
  - In that cycle wb_we is ignored and the head drains.
  - The pipeline holds its write-back signals and re-presents them on the next cycle.
- Push and pop in the same cycle: allowed, and occupancy is unchanged. When full, only a pop is possible, so aux_ready stays 0 until the edge after the pop.
- Forwarding query:
  - q_hit = q_addr!=0 && some live entry has addr==q_addr
  - q_data is taken from the youngest such entry; if there is no hit, q_data=0
  - the incoming same-cycle aux beat is not considered
- Read and write pointers wrap modulo DEPTH. Occupancy is tracked with an extra count bit to distinguish full from empty.

Optional Feature:
- Macro: RF_ARB_BYPASS_EN
- Defined: when the buffer is empty, the primary side is idle (or wb_addr==0) and stall_req==0, an accepted aux beat with aux_addr!=0 is written to rf_* in the same cycle and not enqueued.
- Undefined: every secondary result is enqueued first, so minimum latency is one cycle.

Decomposition:
- Package rf_arb_pkg holds:
  - ADDR_W and DATA_W defaults
  - REG_ZERO constant
  - entry struct typedef rf_arb_entry_t {live, addr, data}
- Sub-module rf_arb_fifo: DEPTH-entry circular buffer with push/pop, a kill-by-address input, and a parallel entry view for the forwarding match. The arbiter top holds the port mux, the starvation counter and the query logic.

Test Plan:
- Idle write-back; aux beat to r5=0x1234 -> rf_we=1, r5, 0x1234 one cycle later (same cycle with RF_ARB_BYPASS_EN); aux_ready stays 1.
- wb_we=1 to r3 every cycle, aux to r7 pushed -> head denied 4 cycles, stall_req=1 on the 5th, r7 written that cycle, stall_req=0 the next.
- Aux pushes to r8 and r9 while wb busy -> after the second push aux_ready=0; the first drain cycle restores aux_ready=1 on the following edge.
- Buffer holds r4=0xA; wb writes r4=0xB -> entry killed, rf never receives 0xA; query q_addr=4 gives q_hit=0 afterwards.
- Buffer holds r6=0x1 then r6=0x2; q_addr=6 -> q_hit=1, q_data=0x2; q_addr=0 -> q_hit=0.
- Reset asserted with 2 entries and count=3 -> all outputs 0, aux_ready=1 immediately; no rf write occurs after deassertion.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared types and defaults for the GPR write-port arbiter.
package rf_arb_pkg;

    localparam int RF_ARB_ADDR_W = 5;
    localparam int RF_ARB_DATA_W = 32;

    // Architectural zero register: writes to it are never performed.
    localparam logic [RF_ARB_ADDR_W-1:0] REG_ZERO = 5'd0;

    // One buffered secondary result. live drops when a younger primary
    // write to the same register makes this value obsolete.
    typedef struct packed {
        logic                     live;
        logic [RF_ARB_ADDR_W-1:0] addr;
        logic [RF_ARB_DATA_W-1:0] data;
    } rf_arb_entry_t;

endpackage

// File: rtl/rf_arb_fifo.sv
// In-order circular buffer for secondary write-back results.
// Supports push/pop, a kill-by-address that clears live on matching
// entries, and an age-ordered view (index 0 = head = oldest).
module rf_arb_fifo
    import rf_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            push_i,
    input  rf_arb_entry_t                   push_entry_i,
    input  logic                            pop_i,
    input  logic                            kill_en_i,
    input  logic [RF_ARB_ADDR_W-1:0]        kill_addr_i,
    output logic                            full_o,
    output logic                            empty_o,
    output rf_arb_entry_t [DEPTH-1:0]       view_o,
    output logic [DEPTH-1:0]                view_vld_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0]          wr_ptr_q;
    logic [PTR_W-1:0]          rd_ptr_q;
    logic [PTR_W:0]            count_q;
    rf_arb_entry_t [DEPTH-1:0] mem_q;
    logic                      push_ok_s;
    logic                      pop_ok_s;

    assign full_o    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o   = (count_q == {(PTR_W+1){1'b0}});
    assign push_ok_s = push_i && !full_o;
    assign pop_ok_s  = pop_i && !empty_o;

    // Storage, pointers and occupancy; a same-edge push overrides a kill on its slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {(PTR_W+1){1'b0}};
            mem_q    <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_en_i && (mem_q[i].addr == kill_addr_i)) begin
                    mem_q[i].live <= 1'b0;
                end
            end
            if (push_ok_s) begin
                mem_q[wr_ptr_q] <= push_entry_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Age-ordered view of occupied slots starting at the read pointer.
    always_comb begin
        logic [PTR_W-1:0] idx_s;
        idx_s      = {PTR_W{1'b0}};
        view_o     = '0;
        view_vld_o = {DEPTH{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            idx_s         = rd_ptr_q + PTR_W'(k);
            view_o[k]     = mem_q[idx_s];
            view_vld_o[k] = ((PTR_W+1)'(k) < count_q);
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the GPR write port between the in-order write-back stage and a
// buffered secondary (long-latency) requester. Forces a write-back stall
// when the buffered head has been starved, and offers a forwarding view.
// Optional: define RF_ARB_BYPASS_EN to write an aux beat straight through
// when the buffer is empty and the primary side is idle.
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = RF_ARB_ADDR_W,
    parameter int DATA_W       = RF_ARB_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              aux_valid,
    output logic              aux_ready,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [DATA_W-1:0] aux_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_data,
    output logic              stall_req,
    input  logic [ADDR_W-1:0] q_addr,
    output logic              q_hit,
    output logic [DATA_W-1:0] q_data
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic                      full_s;
    logic                      empty_s;
    rf_arb_entry_t [DEPTH-1:0] view_s;
    logic [DEPTH-1:0]          view_vld_s;
    rf_arb_entry_t             head_s;
    rf_arb_entry_t             push_entry_s;
    logic                      push_fifo_s;
    logic                      pop_s;
    logic                      kill_en_s;
    logic                      starved_s;
    logic                      wb_act_s;
    logic                      accept_s;
    logic                      bypass_s;
    logic [CNT_W-1:0]          cnt_q;
    logic [CNT_W-1:0]          cnt_d;

    assign head_s       = view_s[0];
    assign push_entry_s = '{live: 1'b1, addr: aux_addr, data: aux_data};
    assign aux_ready    = !full_s;
    assign stall_req    = starved_s;

    rf_arb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (push_fifo_s),
        .push_entry_i (push_entry_s),
        .pop_i        (pop_s),
        .kill_en_i    (kill_en_s),
        .kill_addr_i  (wb_addr),
        .full_o       (full_s),
        .empty_o      (empty_s),
        .view_o       (view_s),
        .view_vld_o   (view_vld_s)
    );

    // Port mux, pop/kill/push decisions and next starvation count.
    always_comb begin
        rf_we       = 1'b0;
        rf_addr     = {ADDR_W{1'b0}};
        rf_data     = {DATA_W{1'b0}};
        pop_s       = 1'b0;
        kill_en_s   = 1'b0;
        bypass_s    = 1'b0;
        cnt_d       = cnt_q;
        starved_s   = (cnt_q == CNT_W'(STARVE_LIMIT)) && !empty_s;
        wb_act_s    = wb_we && (wb_addr != REG_ZERO);
        accept_s    = aux_valid && !full_s && reset;

        if (!starved_s && wb_act_s) begin
            rf_we     = 1'b1;
            rf_addr   = wb_addr;
            rf_data   = wb_data;
            kill_en_s = 1'b1;
            // A dead head costs no port slot, so retire it alongside.
            pop_s     = !empty_s && !head_s.live;
        end else if (!empty_s) begin
            pop_s   = 1'b1;
            rf_we   = head_s.live;
            rf_addr = head_s.addr;
            rf_data = head_s.data;
        end else begin
`ifdef RF_ARB_BYPASS_EN
            if (accept_s && (aux_addr != REG_ZERO)) begin
                bypass_s = 1'b1;
                rf_we    = 1'b1;
                rf_addr  = aux_addr;
                rf_data  = aux_data;
            end else begin
                bypass_s = 1'b0;
            end
`else
            bypass_s = 1'b0;
`endif
        end

        // Beats to the zero register complete the handshake but are dropped.
        push_fifo_s = accept_s && (aux_addr != REG_ZERO) && !bypass_s;

        if (empty_s || pop_s) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (cnt_q < CNT_W'(STARVE_LIMIT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        if (!reset) begin
            rf_we   = 1'b0;
            rf_addr = {ADDR_W{1'b0}};
            rf_data = {DATA_W{1'b0}};
        end else begin
            rf_we   = rf_we;
        end
    end

    // Starvation counter for the buffered head.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Forwarding match: the youngest live entry with the queried address wins.
    always_comb begin
        q_hit  = 1'b0;
        q_data = {DATA_W{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            if (view_vld_s[k] && view_s[k].live && (view_s[k].addr == q_addr)
                && (q_addr != REG_ZERO)) begin
                q_hit  = 1'b1;
                q_data = view_s[k].data;
            end else begin
                q_hit  = q_hit;
            end
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter.
module tb_rf_write_arbiter;

    logic        clk;
    logic        reset;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        aux_valid;
    logic        aux_ready;
    logic [4:0]  aux_addr;
    logic [31:0] aux_data;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        stall_req;
    logic [4:0]  q_addr;
    logic        q_hit;
    logic [31:0] q_data;

    int checks   = 0;
    int failures = 0;

    rf_write_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .aux_valid (aux_valid),
        .aux_ready (aux_ready),
        .aux_addr  (aux_addr),
        .aux_data  (aux_data),
        .rf_we     (rf_we),
        .rf_addr   (rf_addr),
        .rf_data   (rf_data),
        .stall_req (stall_req),
        .q_addr    (q_addr),
        .q_hit     (q_hit),
        .q_data    (q_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and land 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_set(input logic we, input logic [4:0] a, input logic [31:0] d);
        wb_we   = we;
        wb_addr = a;
        wb_data = d;
    endtask

    task automatic aux_set(input logic v, input logic [4:0] a, input logic [31:0] d);
        aux_valid = v;
        aux_addr  = a;
        aux_data  = d;
    endtask

    initial begin
        reset  = 1'b0;
        q_addr = 5'd0;
        wb_set(1'b0, 5'd0, 32'd0);
        aux_set(1'b0, 5'd0, 32'd0);

        // Reset state
        #2;
        chk("rst_aux_ready", {31'd0, aux_ready}, 32'd1);
        chk("rst_rf_we",     {31'd0, rf_we},     32'd0);
        chk("rst_rf_addr",   {27'd0, rf_addr},   32'd0);
        chk("rst_rf_data",   rf_data,            32'd0);
        chk("rst_stall",     {31'd0, stall_req}, 32'd0);
        chk("rst_q_hit",     {31'd0, q_hit},     32'd0);
        chk("rst_q_data",    q_data,             32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // T1: idle write-back, aux beat to r5
        aux_set(1'b1, 5'd5, 32'h1234);
        #1;
        chk("t1_ready_c0", {31'd0, aux_ready}, 32'd1);
`ifdef RF_ARB_BYPASS_EN
        chk("t1_we_c0",   {31'd0, rf_we},   32'd1);
        chk("t1_addr_c0", {27'd0, rf_addr}, 32'd5);
        chk("t1_data_c0", rf_data,          32'h1234);
`else
        chk("t1_we_c0",   {31'd0, rf_we},   32'd0);
`endif
        tick();
        aux_set(1'b0, 5'd0, 32'd0);
        q_addr = 5'd5;
        #1;
        chk("t1_ready_c1", {31'd0, aux_ready}, 32'd1);
`ifdef RF_ARB_BYPASS_EN
        chk("t1_we_c1",  {31'd0, rf_we}, 32'd0);
        chk("t1_qhit_c1", {31'd0, q_hit}, 32'd0);
`else
        chk("t1_we_c1",   {31'd0, rf_we},   32'd1);
        chk("t1_addr_c1", {27'd0, rf_addr}, 32'd5);
        chk("t1_data_c1", rf_data,          32'h1234);
        chk("t1_qhit_c1", {31'd0, q_hit},   32'd1);
        chk("t1_qdat_c1", q_data,           32'h1234);
`endif
        q_addr = 5'd0;
        tick();
        #1;
        chk("t1_we_c2", {31'd0, rf_we}, 32'd0);

        // T2: write-back busy to r3, aux r7 starves then forces a stall
        wb_set(1'b1, 5'd3, 32'h33);
        aux_set(1'b1, 5'd7, 32'h77);
        #1;
        chk("t2_addr_push", {27'd0, rf_addr}, 32'd3);
        tick();
        aux_set(1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_no_stall", {31'd0, stall_req}, 32'd0);
            chk("t2_wb_addr",  {27'd0, rf_addr},   32'd3);
            tick();
        end
        #1;
        chk("t2_stall",      {31'd0, stall_req}, 32'd1);
        chk("t2_stall_we",   {31'd0, rf_we},     32'd1);
        chk("t2_stall_addr", {27'd0, rf_addr},   32'd7);
        chk("t2_stall_data", rf_data,            32'h77);
        tick();
        #1;
        chk("t2_unstall",    {31'd0, stall_req}, 32'd0);
        chk("t2_after_addr", {27'd0, rf_addr},   32'd3);
        chk("t2_after_data", rf_data,            32'h33);
        tick();

        // T3: two pushes fill the buffer; drain restores aux_ready next edge
        aux_set(1'b1, 5'd8, 32'h88);
        #1;
        chk("t3_ready_p0", {31'd0, aux_ready}, 32'd1);
        tick();
        aux_set(1'b1, 5'd9, 32'h99);
        #1;
        chk("t3_ready_p1", {31'd0, aux_ready}, 32'd1);
        tick();
        aux_set(1'b0, 5'd0, 32'd0);
        wb_set(1'b0, 5'd0, 32'd0);
        #1;
        chk("t3_full_ready", {31'd0, aux_ready}, 32'd0);
        chk("t3_d0_we",      {31'd0, rf_we},     32'd1);
        chk("t3_d0_addr",    {27'd0, rf_addr},   32'd8);
        chk("t3_d0_data",    rf_data,            32'h88);
        tick();
        #1;
        chk("t3_ready_back", {31'd0, aux_ready}, 32'd1);
        chk("t3_d1_addr",    {27'd0, rf_addr},   32'd9);
        chk("t3_d1_data",    rf_data,            32'h99);
        tick();
        #1;
        chk("t3_empty_we", {31'd0, rf_we}, 32'd0);

        // T4: WAW kill of buffered r4=0xA by write-back r4=0xB
        wb_set(1'b1, 5'd3, 32'h33);
        aux_set(1'b1, 5'd4, 32'hA);
        tick();
        aux_set(1'b0, 5'd0, 32'd0);
        wb_set(1'b1, 5'd4, 32'hB);
        q_addr = 5'd4;
        #1;
        chk("t4_qhit_pre", {31'd0, q_hit},   32'd1);
        chk("t4_qdat_pre", q_data,           32'hA);
        chk("t4_wb_addr",  {27'd0, rf_addr}, 32'd4);
        chk("t4_wb_data",  rf_data,          32'hB);
        tick();
        wb_set(1'b0, 5'd0, 32'd0);
        #1;
        chk("t4_qhit_post", {31'd0, q_hit}, 32'd0);
        chk("t4_dead_we",   {31'd0, rf_we}, 32'd0);
        tick();
        #1;
        chk("t4_empty_we", {31'd0, rf_we}, 32'd0);
        q_addr = 5'd0;

        // T5: youngest-match forwarding with two r6 entries
        wb_set(1'b1, 5'd3, 32'h33);
        aux_set(1'b1, 5'd6, 32'h1);
        tick();
        aux_set(1'b1, 5'd6, 32'h2);
        tick();
        aux_set(1'b0, 5'd0, 32'd0);
        q_addr = 5'd6;
        #1;
        chk("t5_qhit",  {31'd0, q_hit}, 32'd1);
        chk("t5_qdata", q_data,         32'h2);
        q_addr = 5'd0;
        #1;
        chk("t5_q0_hit",  {31'd0, q_hit}, 32'd0);
        chk("t5_q0_data", q_data,         32'd0);
        tick();
        wb_set(1'b0, 5'd0, 32'd0);
        #1;
        chk("t5_d0_data", rf_data, 32'h1);
        tick();
        #1;
        chk("t5_d1_data", rf_data, 32'h2);
        tick();

        // T6: reset with two entries and count=3
        wb_set(1'b1, 5'd3, 32'h33);
        aux_set(1'b1, 5'd10, 32'hAA);
        tick();
        aux_set(1'b1, 5'd11, 32'hBB);
        tick();
        aux_set(1'b0, 5'd0, 32'd0);
        tick();
        tick();
        #1;
        chk("t6_pre_stall", {31'd0, stall_req}, 32'd0);
        chk("t6_pre_full",  {31'd0, aux_ready}, 32'd0);
        reset = 1'b0;
        #1;
        chk("t6_ready", {31'd0, aux_ready}, 32'd1);
        chk("t6_we",    {31'd0, rf_we},     32'd0);
        chk("t6_addr",  {27'd0, rf_addr},   32'd0);
        chk("t6_data",  rf_data,            32'd0);
        chk("t6_stall", {31'd0, stall_req}, 32'd0);
        wb_set(1'b0, 5'd0, 32'd0);
        q_addr = 5'd10;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t6_post_we",   {31'd0, rf_we}, 32'd0);
            chk("t6_post_qhit", {31'd0, q_hit}, 32'd0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
